friscv_mpu_gate: RTL and testbench
==================================

FRISCV_MPU_GATE -- requirements
Module: friscv_mpu_gate

Interface
REQ-001 SHALL have parameter AXI_ADDR_W, default 32, AR address width.
REQ-002 SHALL have parameter AXI_ID_W, default 8, AXI ID width.
REQ-003 SHALL have parameter XLEN, default 32, R data width.
REQ-004 SHALL have parameter MAX_OUTSTANDING, default 4, maximum forwarded reads awaiting their last R beat.
REQ-005 SHALL have port aclk  in  1  clock; the block uses this single clock, rising edge.
REQ-006 SHALL have port areset  in  1  reset, asynchronous, active-high.
REQ-007 SHALL have port s_arvalid  in  1  upstream AR valid.
REQ-008 SHALL have port s_arready  out  1  upstream AR ready.
REQ-009 SHALL have port s_araddr  in  AXI_ADDR_W  upstream AR address.
REQ-010 SHALL have port s_arid  in  AXI_ID_W  upstream AR ID.
REQ-011 SHALL have port m_arvalid  out  1  downstream AR valid.
REQ-012 SHALL have port m_arready  in  1  downstream AR ready.
REQ-013 SHALL have port m_araddr  out  AXI_ADDR_W  downstream AR address.
REQ-014 SHALL have port m_arid  out  AXI_ID_W  downstream AR ID.
REQ-015 SHALL have port m_rvalid  in  1  downstream R valid.
REQ-016 SHALL have port m_rready  out  1  downstream R ready.
REQ-017 SHALL have port m_rid / m_rresp / m_rdata / m_rlast  in  AXI_ID_W / 2 / XLEN / 1  downstream R payload.
REQ-018 SHALL have port s_rvalid  out  1  upstream R valid.
REQ-019 SHALL have port s_rready  in  1  upstream R ready.
REQ-020 SHALL have port s_rid / s_rresp / s_rdata / s_rlast  out  AXI_ID_W / 2 / XLEN / 1  upstream R payload.
REQ-021 SHALL have port mpu_addr  out  AXI_ADDR_W  registered address presented to the MPU checker.
REQ-022 SHALL have port mpu_allow  in  1  combinational permit from the MPU for mpu_addr.
REQ-023 SHALL have port fault_addr  out  AXI_ADDR_W  address of the last denied request.

Function
REQ-024 SHALL implement FSM IDLE, CHECK, FORWARD, DRAIN, FAULT; s_arready = 1 only in IDLE.
REQ-025 In IDLE, the s_arvalid&s_arready handshake SHALL capture s_araddr into mpu_addr and capture s_arid, then the FSM moves to CHECK.
REQ-026 In CHECK (exactly 1 cycle), the FSM SHALL sample mpu_allow: if 1 -> FORWARD; if 0 and outstanding!=0 -> DRAIN; if 0 and outstanding==0 -> FAULT.
REQ-027 In FORWARD, m_arvalid SHALL be 1 only while outstanding<MAX_OUTSTANDING, with m_araddr=mpu_addr and m_arid=captured ID; on m_arready the FSM moves to IDLE; m_arvalid SHALL not drop once asserted until the handshake.
REQ-028 The outstanding counter SHALL be +1 on the m_ar handshake and -1 on an m_r handshake with m_rlast=1; when both occur in one cycle it SHALL be unchanged; it SHALL never exceed MAX_OUTSTANDING or underflow.
REQ-029 DRAIN SHALL hold until outstanding==0, then move to FAULT; this prevents a fault response from overtaking earlier responses.
REQ-030 In FAULT: s_rvalid=1, s_rresp=2'b10 (SLVERR), s_rdata=0, s_rlast=1, s_rid=captured ID; on s_rready the FSM moves to IDLE.
REQ-031 Outside FAULT, the R channel SHALL be a combinational pass-through (s_r* = m_r*, m_rready = s_rready); in FAULT, m_rready SHALL be 0.
REQ-032 Minimum AR latency upstream-to-downstream SHALL be 2 cycles (capture, check); throughput SHALL be one request per 3 cycles.

Reset
REQ-033 areset SHALL asynchronously force: FSM=IDLE, outstanding=0, mpu_addr=0, fault_addr=0, m_arvalid=0; s_rvalid SHALL then follow m_rvalid. Reset mid-transaction SHALL drop the held request silently.

Configuration
REQ-034 With macro FRISCV_MPU_FAULT_ADDR_EN defined, fault_addr SHALL load mpu_addr on every CHECK->DRAIN/FAULT transition; without the macro, fault_addr SHALL be tied to 0 and its register omitted.

Structure
REQ-035 The FSM state enum and the RESP_SLVERR=2'b10 constant SHALL live in shared package friscv_mpu_pkg.
REQ-036 The saturating outstanding counter SHALL be sub-module friscv_mpu_gate_cnt (inc, dec, count, full, empty).

Verification
REQ-037 Allowed read to 0x1000 with ID 3 and mpu_allow=1: m_arvalid rises 2 cycles after the handshake; a 4-beat R burst passes unchanged.
REQ-038 Denied read to 0x2000 with ID 5, idle bus: s_rvalid with rresp=2'b10, rid=5, rdata=0, rlast=1; m_arvalid never asserts; fault_addr=0x2000 when the macro is defined.
REQ-039 Two allowed reads outstanding, then a denied read: FSM holds in DRAIN until both rlast beats complete; the SLVERR response follows them.
REQ-040 MAX_OUTSTANDING=4 with m_rvalid held at 0: the 5th allowed request keeps m_arvalid=0 until one rlast handshake occurs.
REQ-041 m_ar handshake and rlast handshake in the same cycle with count=2: count stays 2.
REQ-042 Assert areset during DRAIN: all outputs return to their reset values in the same cycle; the next request is processed normally.

Source files
------------

// File: rtl/friscv_mpu_pkg.sv
// Shared types and constants for the MPU read gate.
//   mpu_state_t : gate FSM state encoding
//   RESP_SLVERR : AXI response code returned for a denied read
//   cnt_width() : bits needed to hold 0..max inclusive
package friscv_mpu_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_CHECK   = 3'd1,
      ST_FORWARD = 3'd2,
      ST_DRAIN   = 3'd3,
      ST_FAULT   = 3'd4
   } mpu_state_t;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   function automatic int cnt_width(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/friscv_mpu_gate_cnt.sv
// Saturating up/down counter of forwarded reads still awaiting their last R beat.
// Ports:
//   aclk, areset : clock, async active-high reset
//   inc          : one read forwarded downstream this cycle
//   dec          : one read completed (rlast handshake) this cycle
//   count        : current number of outstanding reads
//   full, empty  : count == MAX_COUNT / count == 0
module friscv_mpu_gate_cnt
   import friscv_mpu_pkg::*;
#(
   parameter int MAX_COUNT = 4,
   parameter int CNT_W     = cnt_width(MAX_COUNT)
) (
   input  logic             aclk,
   input  logic             areset,
   input  logic             inc,
   input  logic             dec,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty
);

   logic inc_ok;
   logic dec_ok;

   assign full   = (count == CNT_W'(MAX_COUNT));
   assign empty  = (count == '0);
   // Saturate at both ends; a simultaneous inc and dec cancels out.
   assign inc_ok = inc & ~full;
   assign dec_ok = dec & ~empty;

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         count <= '0;
      end else if (inc_ok && !dec_ok) begin
         count <= count + CNT_W'(1);
      end else if (dec_ok && !inc_ok) begin
         count <= count - CNT_W'(1);
      end
   end

endmodule

// File: rtl/friscv_mpu_gate.sv
// MPU read gate: holds one upstream AR request, asks the MPU whether its address
// is permitted, then either forwards it downstream or answers it locally with a
// single-beat SLVERR. R data from downstream passes straight through except while
// the local error beat is being returned.
//
// Optional feature macro: FRISCV_MPU_FAULT_ADDR_EN -- when defined, fault_addr
// records the address of the most recent denied request; otherwise it reads 0.
//
// Ports:
//   aclk, areset            : clock, async active-high reset
//   s_ar* / s_arready       : upstream AR channel (slave side)
//   m_ar* / m_arready       : downstream AR channel (master side)
//   m_r* / m_rready         : downstream R channel
//   s_r* / s_rready         : upstream R channel
//   mpu_addr, mpu_allow     : registered address to MPU checker, its permit
//   fault_addr              : address of the last denied request
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | accepting an upstream AR
// ST_CHECK   | one cycle; MPU verdict on mpu_addr is sampled
// ST_FORWARD | presenting the request downstream (while not at max outstanding)
// ST_DRAIN   | denied; waiting for earlier forwarded reads to finish
// ST_FAULT   | returning the SLVERR beat upstream
module friscv_mpu_gate
   import friscv_mpu_pkg::*;
#(
   parameter int AXI_ADDR_W      = 32,
   parameter int AXI_ID_W        = 8,
   parameter int XLEN            = 32,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                  aclk,
   input  logic                  areset,
   input  logic                  s_arvalid,
   output logic                  s_arready,
   input  logic [AXI_ADDR_W-1:0] s_araddr,
   input  logic [AXI_ID_W-1:0]   s_arid,
   output logic                  m_arvalid,
   input  logic                  m_arready,
   output logic [AXI_ADDR_W-1:0] m_araddr,
   output logic [AXI_ID_W-1:0]   m_arid,
   input  logic                  m_rvalid,
   output logic                  m_rready,
   input  logic [AXI_ID_W-1:0]   m_rid,
   input  logic [1:0]            m_rresp,
   input  logic [XLEN-1:0]       m_rdata,
   input  logic                  m_rlast,
   output logic                  s_rvalid,
   input  logic                  s_rready,
   output logic [AXI_ID_W-1:0]   s_rid,
   output logic [1:0]            s_rresp,
   output logic [XLEN-1:0]       s_rdata,
   output logic                  s_rlast,
   output logic [AXI_ADDR_W-1:0] mpu_addr,
   input  logic                  mpu_allow,
   output logic [AXI_ADDR_W-1:0] fault_addr
);

   localparam int CNT_W = cnt_width(MAX_OUTSTANDING);

   mpu_state_t          state_q;
   mpu_state_t          state_d;
   logic [AXI_ID_W-1:0] arid_q;
   logic [CNT_W-1:0]    cnt_count;
   logic                cnt_full;
   logic                cnt_empty;
   logic                ar_hs;
   logic                m_ar_hs;
   logic                m_r_last_hs;

   assign ar_hs       = s_arvalid & s_arready;
   assign m_ar_hs     = m_arvalid & m_arready;
   assign m_r_last_hs = m_rvalid & m_rready & m_rlast;

   friscv_mpu_gate_cnt #(
      .MAX_COUNT (MAX_OUTSTANDING),
      .CNT_W     (CNT_W)
   ) u_cnt (
      .aclk   (aclk),
      .areset (areset),
      .inc    (m_ar_hs),
      .dec    (m_r_last_hs),
      .count  (cnt_count),
      .full   (cnt_full),
      .empty  (cnt_empty)
   );

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         mpu_addr <= '0;
         arid_q   <= '0;
      end else if (ar_hs) begin
         mpu_addr <= s_araddr;
         arid_q   <= s_arid;
      end
   end

   always_comb begin
      state_d   = state_q;
      s_arready = 1'b0;
      m_arvalid = 1'b0;
      case (state_q)
         ST_IDLE: begin
            s_arready = 1'b1;
            if (s_arvalid) begin
               state_d = ST_CHECK;
            end
         end
         ST_CHECK: begin
            if (mpu_allow) begin
               state_d = ST_FORWARD;
            end else if (cnt_empty) begin
               state_d = ST_FAULT;
            end else begin
               state_d = ST_DRAIN;
            end
         end
         ST_FORWARD: begin
            // Nothing but an R completion changes cnt_full here, so valid
            // cannot fall once raised.
            m_arvalid = ~cnt_full;
            if (m_ar_hs) begin
               state_d = ST_IDLE;
            end
         end
         ST_DRAIN: begin
            if (cnt_count == '0) begin
               state_d = ST_FAULT;
            end
         end
         ST_FAULT: begin
            if (s_rready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign m_araddr = mpu_addr;
   assign m_arid   = arid_q;

   always_comb begin
      s_rvalid = m_rvalid;
      s_rid    = m_rid;
      s_rresp  = m_rresp;
      s_rdata  = m_rdata;
      s_rlast  = m_rlast;
      m_rready = s_rready;
      if (state_q == ST_FAULT) begin
         s_rvalid = 1'b1;
         s_rid    = arid_q;
         s_rresp  = RESP_SLVERR;
         s_rdata  = '0;
         s_rlast  = 1'b1;
         m_rready = 1'b0;
      end
   end

`ifdef FRISCV_MPU_FAULT_ADDR_EN
   logic fault_load;

   assign fault_load = (state_q == ST_CHECK) && !mpu_allow;

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         fault_addr <= '0;
      end else if (fault_load) begin
         fault_addr <= mpu_addr;
      end
   end
`else
   assign fault_addr = '0;
`endif

endmodule

// File: tb/tb_friscv_mpu_gate.sv
// Self-checking bench for friscv_mpu_gate: directed scenarios plus a randomized
// request stream checked against a transaction-level model of outstanding reads.
module tb_friscv_mpu_gate;

   localparam int AW   = 32;
   localparam int IW   = 8;
   localparam int DW   = 32;
   localparam int MAXO = 4;
   localparam logic [1:0] SLVERR = 2'b10;

   logic          aclk = 1'b0;
   logic          areset;
   logic          s_arvalid, s_arready;
   logic [AW-1:0] s_araddr;
   logic [IW-1:0] s_arid;
   logic          m_arvalid, m_arready;
   logic [AW-1:0] m_araddr;
   logic [IW-1:0] m_arid;
   logic          m_rvalid, m_rready;
   logic [IW-1:0] m_rid;
   logic [1:0]    m_rresp;
   logic [DW-1:0] m_rdata;
   logic          m_rlast;
   logic          s_rvalid, s_rready;
   logic [IW-1:0] s_rid;
   logic [1:0]    s_rresp;
   logic [DW-1:0] s_rdata;
   logic          s_rlast;
   logic [AW-1:0] mpu_addr;
   logic          mpu_allow;
   logic [AW-1:0] fault_addr;

   int checks   = 0;
   int failures = 0;

   logic [IW-1:0] pend_id[$];
   int            pend_beats[$];

   always #5 aclk = ~aclk;

   friscv_mpu_gate #(
      .AXI_ADDR_W(AW), .AXI_ID_W(IW), .XLEN(DW), .MAX_OUTSTANDING(MAXO)
   ) dut (
      .aclk(aclk), .areset(areset),
      .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arid(s_arid),
      .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arid(m_arid),
      .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rid(m_rid), .m_rresp(m_rresp),
      .m_rdata(m_rdata), .m_rlast(m_rlast),
      .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rid(s_rid), .s_rresp(s_rresp),
      .s_rdata(s_rdata), .s_rlast(s_rlast),
      .mpu_addr(mpu_addr), .mpu_allow(mpu_allow), .fault_addr(fault_addr)
   );

   function automatic logic [AW-1:0] exp_fault_addr(input logic [AW-1:0] a);
`ifdef FRISCV_MPU_FAULT_ADDR_EN
      return a;
`else
      return '0;
`endif
   endfunction

   // All tasks start and end at 1 time unit after a rising edge.
   task automatic reset_dut();
      areset = 1'b1;
      s_arvalid = 0; s_araddr = '0; s_arid = '0; m_arready = 0;
      m_rvalid = 0; m_rid = '0; m_rresp = '0; m_rdata = '0; m_rlast = 0;
      s_rready = 1; mpu_allow = 0;
      pend_id.delete(); pend_beats.delete();
      repeat (2) @(posedge aclk);
      #1 areset = 1'b0;
      @(posedge aclk); #1;
   endtask

   task automatic send_ar(input logic [AW-1:0] a, input logic [IW-1:0] id, output bit ok);
      ok = 0;
      s_araddr = a; s_arid = id; s_arvalid = 1'b1;
      for (int i = 0; i < 40; i++) begin
         #1;
         if (s_arready === 1'b1) begin
            ok = 1;
            @(posedge aclk); #1;
            break;
         end
         @(posedge aclk); #1;
      end
      s_arvalid = 1'b0;
   endtask

   task automatic accept_ar(output bit ok, output logic [AW-1:0] a, output logic [IW-1:0] id);
      ok = 0; a = '0; id = '0;
      m_arready = 1'b1;
      for (int i = 0; i < 40; i++) begin
         #1;
         if (m_arvalid === 1'b1) begin
            a = m_araddr; id = m_arid; ok = 1;
            @(posedge aclk); #1;
            break;
         end
         @(posedge aclk); #1;
      end
      m_arready = 1'b0;
   endtask

   // Drives one downstream burst; bad counts beats not seen unchanged upstream.
   task automatic return_burst(input logic [IW-1:0] id, input int beats, output int bad);
      bad = 0;
      s_rready = 1'b1;
      for (int b = 0; b < beats; b++) begin
         m_rvalid = 1'b1; m_rid = id; m_rdata = $urandom;
         m_rresp = 2'($urandom_range(0, 3)); m_rlast = (b == beats - 1);
         #1;
         if (s_rvalid !== 1'b1 || s_rid !== id || s_rdata !== m_rdata ||
             s_rresp !== m_rresp || s_rlast !== m_rlast || m_rready !== 1'b1) bad++;
         @(posedge aclk); #1;
      end
      m_rvalid = 1'b0; m_rlast = 1'b0;
   endtask

   task automatic wait_fault(output bit ok, output logic [IW-1:0] rid, output logic [1:0] rresp,
                             output logic [DW-1:0] rdata, output logic rlast, output logic mrr);
      ok = 0; rid = '0; rresp = '0; rdata = '0; rlast = 0; mrr = 0;
      s_rready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         #1;
         if (s_rvalid === 1'b1) begin
            rid = s_rid; rresp = s_rresp; rdata = s_rdata; rlast = s_rlast; mrr = m_rready;
            ok = 1;
            @(posedge aclk); #1;
            break;
         end
         @(posedge aclk); #1;
      end
   endtask

   task automatic test_reset();
      reset_dut();
      #1;
      checks++; if (s_arready !== 1'b1) begin failures++; $display("FAIL rst_s_arready: got %b want 1", s_arready); end
      checks++; if (m_arvalid !== 1'b0) begin failures++; $display("FAIL rst_m_arvalid: got %b want 0", m_arvalid); end
      checks++; if (mpu_addr !== '0) begin failures++; $display("FAIL rst_mpu_addr: got %h want 0", mpu_addr); end
      checks++; if (fault_addr !== '0) begin failures++; $display("FAIL rst_fault_addr: got %h want 0", fault_addr); end
      m_rvalid = 1'b1; m_rid = 8'h5a; #1;
      checks++; if (s_rvalid !== 1'b1 || s_rid !== 8'h5a) begin failures++; $display("FAIL rst_r_follow: got v=%b id=%h want v=1 id=5a", s_rvalid, s_rid); end
      m_rvalid = 1'b0;
      @(posedge aclk); #1;
   endtask

   task automatic test_allowed();
      bit ok; logic [AW-1:0] a; logic [IW-1:0] id; int bad;
      reset_dut();
      mpu_allow = 1'b1;
      send_ar(32'h1000, 8'd3, ok);
      checks++; if (!ok) begin failures++; $display("FAIL alw_send: handshake got %b want 1", ok); end
      #1;
      checks++; if (m_arvalid !== 1'b0) begin failures++; $display("FAIL alw_lat1: m_arvalid got %b want 0", m_arvalid); end
      checks++; if (mpu_addr !== 32'h1000) begin failures++; $display("FAIL alw_mpu_addr: got %h want 1000", mpu_addr); end
      @(posedge aclk); #1;
      checks++; if (m_arvalid !== 1'b1) begin failures++; $display("FAIL alw_lat2: m_arvalid got %b want 1", m_arvalid); end
      accept_ar(ok, a, id);
      checks++; if (!ok || a !== 32'h1000 || id !== 8'd3) begin failures++; $display("FAIL alw_m_ar: got ok=%b addr=%h id=%h want 1/1000/03", ok, a, id); end
      checks++; if (s_arready !== 1'b1) begin failures++; $display("FAIL alw_idle: s_arready got %b want 1", s_arready); end
      return_burst(8'd3, 4, bad);
      checks++; if (bad !== 0) begin failures++; $display("FAIL alw_burst: bad beats got %0d want 0", bad); end
   endtask

   task automatic test_denied();
      bit ok; logic [IW-1:0] rid; logic [1:0] rresp; logic [DW-1:0] rdata; logic rlast, mrr;
      reset_dut();
      mpu_allow = 1'b0;
      send_ar(32'h2000, 8'd5, ok);
      #1;
      checks++; if (m_arvalid !== 1'b0) begin failures++; $display("FAIL den_m_arvalid: got %b want 0", m_arvalid); end
      wait_fault(ok, rid, rresp, rdata, rlast, mrr);
      checks++; if (!ok) begin failures++; $display("FAIL den_timeout: got no s_rvalid want fault beat"); end
      checks++; if (rid !== 8'd5 || rresp !== SLVERR) begin failures++; $display("FAIL den_id_resp: got id=%h resp=%b want 05/10", rid, rresp); end
      checks++; if (rdata !== '0 || rlast !== 1'b1 || mrr !== 1'b0) begin failures++; $display("FAIL den_beat: got data=%h last=%b m_rready=%b want 0/1/0", rdata, rlast, mrr); end
      checks++; if (fault_addr !== exp_fault_addr(32'h2000)) begin failures++; $display("FAIL den_fault_addr: got %h want %h", fault_addr, exp_fault_addr(32'h2000)); end
      checks++; if (s_arready !== 1'b1 || s_rvalid !== 1'b0) begin failures++; $display("FAIL den_idle: got arready=%b rvalid=%b want 1/0", s_arready, s_rvalid); end
   endtask

   task automatic test_drain();
      bit ok; logic [AW-1:0] a; logic [IW-1:0] id; int bad;
      logic [IW-1:0] rid; logic [1:0] rresp; logic [DW-1:0] rdata; logic rlast, mrr;
      reset_dut();
      mpu_allow = 1'b1;
      send_ar(32'h100, 8'd1, ok); accept_ar(ok, a, id);
      send_ar(32'h200, 8'd2, ok); accept_ar(ok, a, id);
      checks++; if (!ok) begin failures++; $display("FAIL drn_setup: second accept got %b want 1", ok); end
      mpu_allow = 1'b0;
      send_ar(32'h300, 8'd7, ok);
      for (int i = 0; i < 4; i++) begin
         #1; checks++; if (s_rvalid !== 1'b0) begin failures++; $display("FAIL drn_hold0: s_rvalid got %b want 0", s_rvalid); end
         @(posedge aclk); #1;
      end
      return_burst(8'd1, 2, bad);
      checks++; if (bad !== 0) begin failures++; $display("FAIL drn_burst1: bad beats got %0d want 0", bad); end
      for (int i = 0; i < 3; i++) begin
         #1; checks++; if (s_rvalid !== 1'b0) begin failures++; $display("FAIL drn_hold1: s_rvalid got %b want 0", s_rvalid); end
         @(posedge aclk); #1;
      end
      return_burst(8'd2, 3, bad);
      checks++; if (bad !== 0) begin failures++; $display("FAIL drn_burst2: bad beats got %0d want 0", bad); end
      wait_fault(ok, rid, rresp, rdata, rlast, mrr);
      checks++; if (!ok || rid !== 8'd7 || rresp !== SLVERR) begin failures++; $display("FAIL drn_fault: got ok=%b id=%h resp=%b want 1/07/10", ok, rid, rresp); end
   endtask

   task automatic test_max_outstanding();
      bit ok; logic [AW-1:0] a; logic [IW-1:0] id; int bad;
      reset_dut();
      mpu_allow = 1'b1;
      for (int k = 0; k < MAXO; k++) begin
         send_ar(32'h4000 + 32'(k * 4), IW'(k), ok);
         accept_ar(ok, a, id);
      end
      checks++; if (!ok) begin failures++; $display("FAIL max_setup: fourth accept got %b want 1", ok); end
      send_ar(32'h4100, 8'd9, ok);
      m_arready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         #1; checks++; if (m_arvalid !== 1'b0) begin failures++; $display("FAIL max_block: m_arvalid got %b want 0", m_arvalid); end
         @(posedge aclk); #1;
      end
      m_arready = 1'b0;
      return_burst(8'd0, 1, bad);
      accept_ar(ok, a, id);
      checks++; if (!ok || id !== 8'd9 || a !== 32'h4100) begin failures++; $display("FAIL max_release: got ok=%b id=%h addr=%h want 1/09/4100", ok, id, a); end
   endtask

   task automatic test_simultaneous();
      bit ok; logic [AW-1:0] a; logic [IW-1:0] id;
      reset_dut();
      mpu_allow = 1'b1;
      send_ar(32'h10, 8'd1, ok); accept_ar(ok, a, id);
      send_ar(32'h20, 8'd2, ok); accept_ar(ok, a, id);
      send_ar(32'h30, 8'd3, ok);
      @(posedge aclk); #1;
      checks++; if (m_arvalid !== 1'b1) begin failures++; $display("FAIL sim_fwd: m_arvalid got %b want 1", m_arvalid); end
      m_arready = 1'b1; m_rvalid = 1'b1; m_rid = 8'd1; m_rlast = 1'b1; m_rdata = $urandom; s_rready = 1'b1;
      @(posedge aclk); #1;
      m_arready = 1'b0; m_rvalid = 1'b0; m_rlast = 1'b0;
      // two in flight now: exactly two more fit before the cap
      send_ar(32'h40, 8'd4, ok); accept_ar(ok, a, id);
      checks++; if (!ok) begin failures++; $display("FAIL sim_third: accept got %b want 1", ok); end
      send_ar(32'h50, 8'd5, ok); accept_ar(ok, a, id);
      checks++; if (!ok) begin failures++; $display("FAIL sim_fourth: accept got %b want 1", ok); end
      send_ar(32'h60, 8'd6, ok);
      m_arready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1; checks++; if (m_arvalid !== 1'b0) begin failures++; $display("FAIL sim_full: m_arvalid got %b want 0", m_arvalid); end
         @(posedge aclk); #1;
      end
      m_arready = 1'b0;
   endtask

   task automatic test_reset_in_drain();
      bit ok; logic [AW-1:0] a; logic [IW-1:0] id;
      logic [IW-1:0] rid; logic [1:0] rresp; logic [DW-1:0] rdata; logic rlast, mrr;
      reset_dut();
      mpu_allow = 1'b1;
      send_ar(32'h500, 8'd1, ok); accept_ar(ok, a, id);
      mpu_allow = 1'b0;
      send_ar(32'h600, 8'd2, ok);
      @(posedge aclk); #1;
      m_rvalid = 1'b1; m_rid = 8'h33; m_rlast = 1'b0;
      #2 areset = 1'b1;
      #1;
      checks++; if (s_arready !== 1'b1 || m_arvalid !== 1'b0) begin failures++; $display("FAIL rsd_ar: got arready=%b arvalid=%b want 1/0", s_arready, m_arvalid); end
      checks++; if (mpu_addr !== '0 || fault_addr !== '0) begin failures++; $display("FAIL rsd_regs: got mpu=%h fault=%h want 0/0", mpu_addr, fault_addr); end
      checks++; if (s_rvalid !== 1'b1 || s_rid !== 8'h33) begin failures++; $display("FAIL rsd_r_follow: got v=%b id=%h want 1/33", s_rvalid, s_rid); end
      m_rvalid = 1'b0;
      @(posedge aclk); #1 areset = 1'b0;
      @(posedge aclk); #1;
      send_ar(32'h700, 8'd9, ok);
      wait_fault(ok, rid, rresp, rdata, rlast, mrr);
      checks++; if (!ok || rid !== 8'd9 || rresp !== SLVERR) begin failures++; $display("FAIL rsd_fault: got ok=%b id=%h resp=%b want 1/09/10", ok, rid, rresp); end
      mpu_allow = 1'b1;
      send_ar(32'h800, 8'd4, ok); accept_ar(ok, a, id);
      checks++; if (!ok || a !== 32'h800 || id !== 8'd4) begin failures++; $display("FAIL rsd_next: got ok=%b addr=%h id=%h want 1/800/04", ok, a, id); end
   endtask

   task automatic test_random();
      bit ok, allow; logic [AW-1:0] addr, a; logic [IW-1:0] rid_exp, id; int bad;
      logic [IW-1:0] rid; logic [1:0] rresp; logic [DW-1:0] rdata; logic rlast, mrr;
      reset_dut();
      for (int t = 0; t < 40; t++) begin
         if (pend_id.size() > 0 && $urandom_range(0, 2) == 0) begin
            return_burst(pend_id[0], pend_beats[0], bad);
            void'(pend_id.pop_front()); void'(pend_beats.pop_front());
            checks++; if (bad !== 0) begin failures++; $display("FAIL rnd_burst: bad beats got %0d want 0", bad); end
         end
         addr = $urandom; rid_exp = IW'($urandom_range(0, 255)); allow = ($urandom_range(0, 3) != 0);
         mpu_allow = allow;
         send_ar(addr, rid_exp, ok);
         checks++; if (!ok || mpu_addr !== addr) begin failures++; $display("FAIL rnd_capture: got ok=%b mpu_addr=%h want 1/%h", ok, mpu_addr, addr); end
         if (allow) begin
            if (pend_id.size() == MAXO) begin
               m_arready = 1'b1;
               for (int i = 0; i < 3; i++) begin
                  #1; checks++; if (m_arvalid !== 1'b0) begin failures++; $display("FAIL rnd_full: m_arvalid got %b want 0", m_arvalid); end
                  @(posedge aclk); #1;
               end
               m_arready = 1'b0;
               return_burst(pend_id[0], pend_beats[0], bad);
               void'(pend_id.pop_front()); void'(pend_beats.pop_front());
            end
            accept_ar(ok, a, id);
            checks++; if (!ok || a !== addr || id !== rid_exp) begin failures++; $display("FAIL rnd_fwd: got ok=%b addr=%h id=%h want 1/%h/%h", ok, a, id, addr, rid_exp); end
            pend_id.push_back(rid_exp); pend_beats.push_back($urandom_range(1, 4));
         end else begin
            if (pend_id.size() > 0) begin
               for (int i = 0; i < 3; i++) begin
                  #1; checks++; if (s_rvalid !== 1'b0 || m_arvalid !== 1'b0) begin failures++; $display("FAIL rnd_drain: got rvalid=%b arvalid=%b want 0/0", s_rvalid, m_arvalid); end
                  @(posedge aclk); #1;
               end
               while (pend_id.size() > 0) begin
                  return_burst(pend_id[0], pend_beats[0], bad);
                  void'(pend_id.pop_front()); void'(pend_beats.pop_front());
                  checks++; if (bad !== 0) begin failures++; $display("FAIL rnd_drain_burst: bad beats got %0d want 0", bad); end
               end
            end
            wait_fault(ok, rid, rresp, rdata, rlast, mrr);
            checks++; if (!ok || rid !== rid_exp || rresp !== SLVERR || rdata !== '0 || rlast !== 1'b1) begin
               failures++; $display("FAIL rnd_fault: got ok=%b id=%h resp=%b data=%h last=%b want 1/%h/10/0/1", ok, rid, rresp, rdata, rlast, rid_exp);
            end
            checks++; if (fault_addr !== exp_fault_addr(addr)) begin failures++; $display("FAIL rnd_fault_addr: got %h want %h", fault_addr, exp_fault_addr(addr)); end
         end
      end
      while (pend_id.size() > 0) begin
         return_burst(pend_id[0], pend_beats[0], bad);
         void'(pend_id.pop_front()); void'(pend_beats.pop_front());
         checks++; if (bad !== 0) begin failures++; $display("FAIL rnd_final_burst: bad beats got %0d want 0", bad); end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_allowed();
      test_denied();
      test_drain();
      test_max_outstanding();
      test_simultaneous();
      test_reset_in_drain();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
